pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage RISC-V pipeline. It detects load-use hazards, ID-stage taken-branch redirects, and multi-cycle data-memory accesses, and drives the hold/flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. A small FSM freezes the pipeline while the data memory is busy. Counters provide stall statistics and a memory-timeout error flag.

## Interface
Parameters:
- `CNT_W`, default 32: width of the stall-cycle counter.
- `MEM_TIMEOUT`, default 64: maximum number of MEM_WAIT cycles before `mem_err_o` sets.

Ports:
- `clk_i`, in, 1: single clock; all state updates on the rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `id_rs1_i`, `id_rs2_i`, in, 5: source register indices of the instruction in IF/ID.
- `ex_memread_i`, in, 1: the instruction in ID/EX is a load.
- `ex_rd_i`, in, 5: destination register of the instruction in ID/EX.
- `branch_taken_i`, in, 1: branch or jump resolved taken in ID this cycle.
- `mem_req_i`, in, 1: the instruction in EX/MEM accesses data memory this cycle.
- `mem_ready_i`, in, 1: data memory completes the access this cycle.
- `pc_write_o`, out, 1: PC update enable.
- `if_id_stall_o`, out, 1: IF/ID hold.
- `if_id_flush_o`, out, 1: IF/ID clear to zero.
- `id_ex_bubble_o`, out, 1: load zero controls (NOP) into ID/EX.
- `pipe_hold_o`, out, 1: ID/EX and EX/MEM hold.
- `mem_wb_bubble_o`, out, 1: load a NOP into MEM/WB.
- `stall_cnt_o`, out, `CNT_W`: total stall cycles since reset.
- `mem_err_o`, out, 1: sticky memory-timeout flag.

## Operation
- FSM states: RUN and MEM_WAIT. Reset state is RUN.
- RUN to MEM_WAIT when `mem_req_i && !mem_ready_i`.
- MEM_WAIT to RUN in the cycle `mem_ready_i` is 1.
- `mem_req_i` with `mem_ready_i` in the same cycle costs zero stall cycles.
- Memory freeze applies when `freeze = (state==MEM_WAIT && !mem_ready_i) || (state==RUN && mem_req_i && !mem_ready_i)`. It is combinational from the current state and inputs. While frozen:
  - `pc_write_o` = 0
  - `if_id_stall_o` = 1
  - `pipe_hold_o` = 1
  - `mem_wb_bubble_o` = 1
  - `id_ex_bubble_o` = 0
  - `if_id_flush_o` = 0
  - hazard inputs are ignored.
- Load-use hazard: `lu = ex_memread_i && ex_rd_i!=0 && (ex_rd_i==id_rs1_i || ex_rd_i==id_rs2_i)`. When `lu` and not `freeze`:
  - `pc_write_o` = 0
  - `if_id_stall_o` = 1
  - `id_ex_bubble_o` = 1.
- Branch flush: when `branch_taken_i`, not `lu` and not `freeze`, `if_id_flush_o` = 1 and `pc_write_o` = 1.
- Priority is freeze > load-use > branch. A branch that coincides with a load-use stall is suppressed; it is re-presented by ID next cycle after its operand is available.
- Default (no event): `pc_write_o` = 1 and every other control = 0.
- `if_id_stall_o` and `if_id_flush_o` are never both 1.
- `stall_cnt_o` increments in every cycle where `freeze || lu`. It saturates at all-ones.
- Timeout counter:
  - counts cycles spent in MEM_WAIT and clears on entry to RUN;
  - when it reaches `MEM_TIMEOUT`, `mem_err_o` sets and holds until reset;
  - the FSM keeps waiting; there is no abort.

## Timing
- All control outputs are combinational from state and inputs, and are consumed at the next rising edge by the pipeline registers.
- Load-use costs exactly 1 bubble cycle. A taken branch costs exactly 1 flushed slot.
- A memory access with N wait cycles costs N stall cycles. The pipeline advances on the edge that follows the cycle where `mem_ready_i` = 1.
- Reset values: state RUN, `stall_cnt_o` = 0, `mem_err_o` = 0, timeout counter 0.
- During reset the outputs are `pc_write_o` = 1, `if_id_flush_o` = 1, and every other control 0, which holds IF/ID empty.
- Reset asserted in MEM_WAIT returns the FSM to RUN on the next edge regardless of `mem_ready_i`.

## Structure
- Shared pipeline package holds the FSM state enum (RUN, MEM_WAIT) and the register-index width constant (5).
- The hazard compare is inline.
- One sub-module is natural: `sat_counter` (parameterised width, increment and clear), instantiated for the stall counter and the timeout counter.

## Test plan
- Reset: `rst_i`=1 for 2 cycles, then release. Expect `stall_cnt_o`=0, `mem_err_o`=0, and `pc_write_o`=1 in the first RUN cycle.
- Load-use: `ex_memread_i`=1, `ex_rd_i`=5, `id_rs2_i`=5. Expect `pc_write_o`=0, `if_id_stall_o`=1 and `id_ex_bubble_o`=1 for exactly 1 cycle, then `stall_cnt_o`=1. Repeat with `ex_rd_i`=0: no stall.
- Branch alone: `branch_taken_i`=1 gives `if_id_flush_o`=1 and `pc_write_o`=1. Branch with load-use in the same cycle gives flush 0 and stall 1.
- Memory wait: `mem_req_i`=1 with `mem_ready_i` low for 3 cycles, then high. Expect `pipe_hold_o`=1 and `mem_wb_bubble_o`=1 for 3 cycles, state back to RUN after the ready cycle, and `stall_cnt_o` +3.
- Freeze priority: load-use and `branch_taken_i` asserted during MEM_WAIT. Expect `id_ex_bubble_o`=0 and `if_id_flush_o`=0.
- Timeout: `MEM_TIMEOUT`=4 with `mem_ready_i` low for 6 cycles. `mem_err_o` rises after the 4th MEM_WAIT cycle and stays 1 after ready. Reset in MEM_WAIT gives state RUN and `mem_err_o`=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control slice.
// Holds the memory-wait FSM state encoding and the register-index width.
package pipeline_ctrl_pkg;

    // Architectural register index width (x0..x31).
    localparam int REG_IDX_W = 5;

    // RUN: pipeline advances normally; MEM_WAIT: data memory access outstanding.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pipe_state_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset, counter to zero
//   clr_i  - synchronous clear, wins over increment
//   inc_i  - increment by one; the count sticks at all-ones
//   cnt_o  - current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr_i) begin
            cnt_next = '0;
        end else if (inc_i && (cnt_reg != '1)) begin
            cnt_next = cnt_reg + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Detects load-use hazards, ID-stage taken branches and multi-cycle data
// memory accesses, and drives the hold/flush/bubble controls of the
// pipeline registers. A two-state FSM freezes the pipe while memory is busy.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   id_rs1_i, id_rs2_i    - source registers of the instruction in IF/ID
//   ex_memread_i, ex_rd_i - load flag / destination of the instruction in ID/EX
//   branch_taken_i        - taken branch/jump resolved in ID
//   mem_req_i, mem_ready_i- data memory request / completion
//   pc_write_o            - PC update enable
//   if_id_stall_o         - IF/ID hold
//   if_id_flush_o         - IF/ID clear
//   id_ex_bubble_o        - NOP into ID/EX
//   pipe_hold_o           - ID/EX and EX/MEM hold
//   mem_wb_bubble_o       - NOP into MEM/WB
//   stall_cnt_o           - saturating count of stall cycles since reset
//   mem_err_o             - sticky memory-timeout flag
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 ex_memread_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 branch_taken_i,
    input  logic                 mem_req_i,
    input  logic                 mem_ready_i,
    output logic                 pc_write_o,
    output logic                 if_id_stall_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_bubble_o,
    output logic                 pipe_hold_o,
    output logic                 mem_wb_bubble_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic                 mem_err_o
);

    // Timeout counter is wide enough to hold MEM_TIMEOUT itself.
    localparam int                TO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    pipe_state_t     state_reg;
    pipe_state_t     state_next;
    logic            freeze;
    logic            load_use;
    logic [TO_W-1:0] to_cnt;
    logic            mem_err_reg;
    logic            mem_err_next;

    // A request that completes in its own cycle never freezes the pipe.
    assign freeze = ((state_reg == MEM_WAIT) && !mem_ready_i) ||
                    ((state_reg == RUN) && mem_req_i && !mem_ready_i);

    // x0 is hardwired zero, so a load into it never creates a dependency.
    assign load_use = ex_memread_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= RUN;
            mem_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mem_err_reg <= mem_err_next;
        end
    end

    // Next state and control outputs. Priority: reset > freeze > load-use > branch.
    always_comb begin
        state_next      = state_reg;
        pc_write_o      = 1'b1;
        if_id_stall_o   = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        pipe_hold_o     = 1'b0;
        mem_wb_bubble_o = 1'b0;

        case (state_reg)
            RUN:      if (mem_req_i && !mem_ready_i) state_next = MEM_WAIT;
            MEM_WAIT: if (mem_ready_i)               state_next = RUN;
            default:                                 state_next = RUN;
        endcase

        if (rst_i) begin
            // Keeps IF/ID empty while reset is held.
            if_id_flush_o = 1'b1;
        end else if (freeze) begin
            pc_write_o      = 1'b0;
            if_id_stall_o   = 1'b1;
            pipe_hold_o     = 1'b1;
            mem_wb_bubble_o = 1'b1;
        end else if (load_use) begin
            // A coincident branch is dropped; ID re-resolves it next cycle.
            pc_write_o     = 1'b0;
            if_id_stall_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
        end
    end

    // The flag sets at the end of the MEM_TIMEOUT-th MEM_WAIT cycle.
    always_comb begin
        mem_err_next = mem_err_reg;
        if ((state_reg == MEM_WAIT) && (to_cnt >= TO_LAST)) begin
            mem_err_next = 1'b1;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .inc_i (freeze || load_use),
        .cnt_o (stall_cnt_o)
    );

    // Counts MEM_WAIT cycles; cleared on the edge that returns to RUN.
    sat_counter #(
        .W (TO_W)
    ) u_timeout_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i ((state_reg == MEM_WAIT) && mem_ready_i),
        .inc_i (state_reg == MEM_WAIT),
        .cnt_o (to_cnt)
    );

    assign mem_err_o = mem_err_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the rules.
module tb_pipeline_ctrl;

    localparam int CNT_W       = 8;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       id_rs1_i, id_rs2_i, ex_rd_i;
    logic             ex_memread_i, branch_taken_i, mem_req_i, mem_ready_i;
    logic             pc_write_o, if_id_stall_o, if_id_flush_o;
    logic             id_ex_bubble_o, pipe_hold_o, mem_wb_bubble_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             mem_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: is a memory access outstanding, how long it has
    // been waiting, total stall cycles and the sticky error.
    bit m_wait     = 0;
    int m_wait_cnt = 0;
    int m_stall    = 0;
    bit m_err      = 0;

    always #5 clk_i = ~clk_i;

    pipeline_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .id_rs1_i        (id_rs1_i),
        .id_rs2_i        (id_rs2_i),
        .ex_memread_i    (ex_memread_i),
        .ex_rd_i         (ex_rd_i),
        .branch_taken_i  (branch_taken_i),
        .mem_req_i       (mem_req_i),
        .mem_ready_i     (mem_ready_i),
        .pc_write_o      (pc_write_o),
        .if_id_stall_o   (if_id_stall_o),
        .if_id_flush_o   (if_id_flush_o),
        .id_ex_bubble_o  (id_ex_bubble_o),
        .pipe_hold_o     (pipe_hold_o),
        .mem_wb_bubble_o (mem_wb_bubble_o),
        .stall_cnt_o     (stall_cnt_o),
        .mem_err_o       (mem_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rst, input int rs1, input int rs2, input bit ld,
                         input int rd, input bit br, input bit req, input bit rdy);
        rst_i          = rst;
        id_rs1_i       = 5'(rs1);
        id_rs2_i       = 5'(rs2);
        ex_memread_i   = ld;
        ex_rd_i        = 5'(rd);
        branch_taken_i = br;
        mem_req_i      = req;
        mem_ready_i    = rdy;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model
    // across the rising edge. Control vector is {pc, stall, flush, bubble, hold, wb_bubble}.
    task automatic tick(input string tag);
        bit         frz, lu;
        logic [5:0] exp_ctl, obs_ctl;
        int         exp_cnt;
        @(negedge clk_i);
        frz = m_wait ? !mem_ready_i : (mem_req_i && !mem_ready_i);
        lu  = ex_memread_i && (ex_rd_i != 0) &&
              ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
        if (rst_i)               exp_ctl = 6'b101000;
        else if (frz)            exp_ctl = 6'b010011;
        else if (lu)             exp_ctl = 6'b010100;
        else if (branch_taken_i) exp_ctl = 6'b101000;
        else                     exp_ctl = 6'b100000;
        obs_ctl = {pc_write_o, if_id_stall_o, if_id_flush_o,
                   id_ex_bubble_o, pipe_hold_o, mem_wb_bubble_o};
        exp_cnt = (m_stall > CNT_MAX) ? CNT_MAX : m_stall;
        check({tag, "/ctl"}, 32'(obs_ctl), 32'(exp_ctl));
        check({tag, "/stall_cnt"}, 32'(stall_cnt_o), 32'(exp_cnt));
        check({tag, "/mem_err"}, 32'(mem_err_o), 32'(m_err));
        check({tag, "/stall_and_flush"}, 32'(if_id_stall_o & if_id_flush_o), 32'd0);
        $display("cycle %-14s rst=%0b ld=%0b rd=%0d rs=%0d/%0d br=%0b req=%0b rdy=%0b ctl=%06b cnt=%0d err=%0b",
                 tag, rst_i, ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i, branch_taken_i,
                 mem_req_i, mem_ready_i, obs_ctl, stall_cnt_o, mem_err_o);
        @(posedge clk_i);
        if (rst_i) begin
            m_wait = 0; m_wait_cnt = 0; m_stall = 0; m_err = 0;
        end else begin
            if (frz || lu) m_stall++;
            if (m_wait) begin
                m_wait_cnt++;
                if (m_wait_cnt >= MEM_TIMEOUT) m_err = 1;
                if (mem_ready_i) begin
                    m_wait = 0;
                    m_wait_cnt = 0;
                end
            end else if (mem_req_i && !mem_ready_i) begin
                m_wait = 1;
            end
        end
        #1;
    endtask

    initial begin
        // Reset held for two cycles.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick("reset0");
        tick("reset1");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick("first_run");

        // Load-use on rs2, then the bubble is gone and one stall counted.
        drive(0, 1, 5, 1, 5, 0, 0, 0);
        tick("load_use");
        drive(0, 1, 5, 0, 5, 0, 0, 0);
        tick("after_lu");
        // Load into x0 never stalls.
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        tick("lu_x0");
        // Load-use on rs1.
        drive(0, 7, 2, 1, 7, 0, 0, 0);
        tick("lu_rs1");

        // Branch alone, then branch coinciding with load-use.
        drive(0, 3, 4, 0, 0, 1, 0, 0);
        tick("branch");
        drive(0, 3, 4, 1, 4, 1, 0, 0);
        tick("branch_lu");

        // Zero-wait access.
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        tick("mem_fast");

        // Access with 3 stall cycles, then ready.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            tick("mem_wait");
        end
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        tick("mem_ready");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick("mem_done");

        // Hazards ignored while frozen.
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick("frz_enter");
        drive(0, 6, 6, 1, 6, 1, 1, 0);
        tick("frz_prio");
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        tick("frz_ready");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick("frz_done");

        // Timeout: ready low for six cycles, then ready; flag must stick.
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            tick("timeout");
        end
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        tick("to_ready");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick("to_sticky");

        // Reset while in MEM_WAIT returns to RUN and clears the flag.
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick("rw_enter");
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick("rw_wait");
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        tick("rw_reset");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick("rw_run");

        // Randomized traffic; long enough for the stall counter to saturate.
        for (int i = 0; i < 800; i++) begin
            bit rst, ld, br, req, rdy;
            rst = ($urandom_range(0, 199) == 0);
            ld  = ($urandom_range(0, 9) < 4);
            br  = ($urandom_range(0, 3) == 0);
            req = m_wait ? 1'b1 : ($urandom_range(0, 4) == 0);
            rdy = ($urandom_range(0, 9) < 3);
            drive(rst, $urandom_range(0, 3), $urandom_range(0, 3), ld,
                  $urandom_range(0, 3), br, req, rdy);
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
